// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the full-speed USB receive path.
package usb_rx_pkg;

    // Values follow {d_plus, d_minus} so the synced pins cast straight to a line state.
    typedef enum logic [1:0] {
        LN_SE0 = 2'b00,
        LN_K   = 2'b01,
        LN_J   = 2'b10,
        LN_SE1 = 2'b11
    } line_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_DATA,
        S_EOP,
        S_ERR_WAIT
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    function automatic logic pid_is_legal(input logic [3:0] p);
        case (p)
            PID_OUT, PID_IN, PID_SOF, PID_SETUP, PID_DATA0,
            PID_DATA1, PID_ACK, PID_NAK, PID_STALL: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/usb_rx_param_if.sv
// Receive-side payload read port and packet status bundle.
// master = receiver, slave = downstream packet/endpoint logic.
interface usb_rx_param_if #(parameter int MAX_BYTES = 64);
    logic                             r_enable;
    logic [7:0]                       r_data;
    logic                             empty;
    logic                             full;
    logic                             rcving;
    logic                             r_error;
    logic [3:0]                       PID;
    logic                             pkt_done;
    logic [$clog2(MAX_BYTES+1)-1:0]   byte_cnt;

    modport master (
        input  r_enable,
        output r_data, empty, full, rcving, r_error, PID, pkt_done, byte_cnt
    );

    modport slave (
        output r_enable,
        input  r_data, empty, full, rcving, r_error, PID, pkt_done, byte_cnt
    );
endinterface

// File: rtl/usb_rx_fifo.sv
// Show-ahead payload FIFO: head visible on rd_dat (0 when empty), write visible next cycle.
// Pop-before-push when full; a push that still finds no room is dropped and flagged on drop.
module usb_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             empty,
    output logic             full,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             rd_ok, wr_ok;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_ok  = rd_en && !empty;
    assign wr_ok  = wr_en && (!full || rd_ok);
    assign drop   = wr_en && !wr_ok;
    assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

// File: rtl/usb_rx_param.sv
// Full-speed USB receiver: sync, bit timing recovery, NRZI decode, unstuff, packet FSM, payload FIFO.
// Byte lands in FIFO one cycle after its last bit sample; no line backpressure, full FIFO drops and errors.
module usb_rx_param import usb_rx_pkg::*; #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int MAX_BYTES    = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           d_plus,
    input  logic           d_minus,
    usb_rx_param_if.master rx
);
    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(MAX_BYTES+1);
    localparam logic [PW-1:0] PH_LAST = PW'(CLKS_PER_BIT-1);
    localparam logic [PW-1:0] PH_SMP  = PW'(CLKS_PER_BIT/2-1);

    logic          dp_s1, dp_s2, dp_s3, dm_s1, dm_s2;
    logic [PW-1:0] phase;
    line_t         ln, prev_ln;
    logic          sample_en, is_jk, nrzi_bit, stuff_slot, stuff_err, byte_done, pid_ok;
    logic [6:0]    shreg;
    logic [7:0]    shreg_nx;
    logic [2:0]    bit_cnt, ones_cnt, j_cnt;
    state_t        state, state_d;
    logic          push_vld, fifo_drop, fifo_empty, fifo_full;
    logic [7:0]    push_dat, fifo_dat;
    logic [CW-1:0] byte_cnt;
    logic [3:0]    pid_q;
    logic          err_q, done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            {dp_s1, dp_s2, dp_s3} <= 3'b111;
            {dm_s1, dm_s2}        <= 2'b00;
        end else begin
            {dp_s1, dp_s2, dp_s3} <= {d_plus, dp_s1, dp_s2};
            {dm_s1, dm_s2}        <= {d_minus, dm_s1};
        end
    end

    // Any D+ transition re-centres the bit clock.
    always_ff @(posedge clk) begin
        if (rst || (dp_s2 != dp_s3)) phase <= '0;
        else if (phase == PH_LAST)   phase <= '0;
        else                         phase <= phase + PW'(1);
    end

    assign sample_en  = (phase == PH_SMP);
    assign ln         = line_t'({dp_s2, dm_s2});
    assign is_jk      = (ln == LN_J) || (ln == LN_K);
    assign nrzi_bit   = (ln == prev_ln);
    assign stuff_slot = ((state == S_PID) || (state == S_DATA)) && (ones_cnt == 3'd6);
    assign stuff_err  = sample_en && is_jk && stuff_slot && nrzi_bit;
    assign shreg_nx   = {nrzi_bit, shreg};
    assign byte_done  = sample_en && is_jk && !stuff_slot && (bit_cnt == 3'd7);
    assign pid_ok     = pid_is_legal(shreg_nx[3:0]) && (shreg_nx[7:4] == ~shreg_nx[3:0]);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (sample_en && ln == LN_K) state_d = S_SYNC;
            S_SYNC: if (sample_en) begin
                if (!is_jk)                 state_d = S_ERR_WAIT;
                else if (bit_cnt == 3'd7)   state_d = (shreg_nx == SYNC_BYTE) ? S_PID : S_ERR_WAIT;
            end
            S_PID: if (sample_en) begin
                if (!is_jk || stuff_err)    state_d = S_ERR_WAIT;
                else if (byte_done)         state_d = pid_ok ? S_DATA : S_ERR_WAIT;
            end
            S_DATA: begin
                if (fifo_drop)              state_d = S_ERR_WAIT;
                else if (sample_en) begin
                    if (ln == LN_SE0)       state_d = (bit_cnt == 3'd0) ? S_EOP : S_ERR_WAIT;
                    else if (!is_jk || stuff_err) state_d = S_ERR_WAIT;
                    else if (byte_done && byte_cnt == CW'(MAX_BYTES)) state_d = S_ERR_WAIT;
                end
            end
            S_EOP: if (sample_en) begin
                if (ln == LN_J)             state_d = S_IDLE;
                else if (ln != LN_SE0)      state_d = S_ERR_WAIT;
            end
            S_ERR_WAIT: if (sample_en && ln == LN_J && (prev_ln == LN_SE0 || j_cnt == 3'd7))
                                            state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            ones_cnt <= '0;
            j_cnt    <= '0;
            prev_ln  <= LN_J;
            push_vld <= 1'b0;
            push_dat <= '0;
            byte_cnt <= '0;
            pid_q    <= 4'hF;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            push_vld <= (state == S_DATA) && byte_done && (state_d == S_DATA);
            done_q   <= (state == S_EOP) && (state_d == S_IDLE);
            if (byte_done) push_dat <= shreg_nx;
            if (push_vld && !fifo_drop) byte_cnt <= byte_cnt + CW'(1);
            if (state_d == S_ERR_WAIT && state != S_ERR_WAIT) err_q <= 1'b1;
            if (state == S_PID && state_d == S_DATA) pid_q <= shreg_nx[3:0];
            if (sample_en) begin
                prev_ln <= ln;
                j_cnt   <= (ln != LN_J) ? 3'd0 : (j_cnt == 3'd7) ? j_cnt : j_cnt + 3'd1;
                if (state == S_IDLE && state_d == S_SYNC) begin
                    // The opening K is the first SYNC bit.
                    shreg    <= shreg_nx[7:1];
                    bit_cnt  <= 3'd1;
                    ones_cnt <= '0;
                    err_q    <= 1'b0;
                    byte_cnt <= '0;
                end else if ((state == S_SYNC || state == S_PID || state == S_DATA) && is_jk) begin
                    if (stuff_slot) begin
                        ones_cnt <= '0;
                    end else begin
                        shreg    <= shreg_nx[7:1];
                        bit_cnt  <= bit_cnt + 3'd1;
                        ones_cnt <= (state != S_SYNC && nrzi_bit) ? ones_cnt + 3'd1 : 3'd0;
                    end
                end
            end
        end
    end

    always_comb begin
        rx.rcving   = (state != S_IDLE);
        rx.r_error  = err_q;
        rx.PID      = pid_q;
        rx.pkt_done = done_q;
        rx.byte_cnt = byte_cnt;
        rx.r_data   = fifo_dat;
        rx.empty    = fifo_empty;
        rx.full     = fifo_full;
    end

    usb_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (push_vld),
        .wr_dat (push_dat),
        .rd_en  (rx.r_enable),
        .rd_dat (fifo_dat),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .drop   (fifo_drop)
    );
endmodule

// File: tb/tb_usb_rx_param.sv
// Directed bench: drives NRZI packets on D+/D- and checks status, FIFO contents and error handling.
module tb_usb_rx_param;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dp  = 1'b1;
    logic dm  = 1'b0;

    always #5 clk = ~clk;

    usb_rx_param_if #(.MAX_BYTES(5)) bus ();

    usb_rx_param #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .MAX_BYTES(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .d_plus  (dp),
        .d_minus (dm),
        .rx      (bus)
    );

    int         n_chk    = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    bit         drain_on = 1'b0;
    bit         corrupt  = 1'b0;
    int         ones     = 0;
    logic [1:0] cur      = 2'b10;
    logic [7:0] got[$];
    logic [7:0] pl[$];

    // Reader: pops whenever enabled and records every byte it takes.
    always @(negedge clk) begin
        if (drain_on && bus.empty === 1'b0) begin
            got.push_back(bus.r_data);
            bus.r_enable = 1'b1;
        end else begin
            bus.r_enable = 1'b0;
        end
        if (bus.pkt_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic sym(input logic [1:0] l);
        dp = l[1];
        dm = l[0];
        repeat (CPB) @(negedge clk);
    endtask

    task automatic nrzi(input bit b);
        if (!b) cur = ~cur;
        sym(cur);
    endtask

    task automatic dbit(input bit b);
        nrzi(b);
        if (b) ones++;
        else   ones = 0;
        if (ones == 6) begin
            nrzi(corrupt);
            corrupt = 1'b0;
            ones    = 0;
        end
    endtask

    task automatic tx_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) dbit(v[i]);
    endtask

    task automatic tx_sync();
        for (int i = 0; i < 8; i++) nrzi(i == 7);
        ones = 0;
    endtask

    task automatic tx_eop();
        sym(2'b00);
        sym(2'b00);
        cur = 2'b10;
        sym(cur);
    endtask

    task automatic idle(input int n);
        cur = 2'b10;
        repeat (n) sym(cur);
    endtask

    task automatic tx_pkt(input logic [3:0] pid);
        tx_sync();
        tx_byte({~pid, pid});
        foreach (pl[i]) tx_byte(pl[i]);
        tx_eop();
        idle(4);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_r_data",   bus.r_data,   8'h00);
        chk("rst_empty",    bus.empty,    1'b1);
        chk("rst_full",     bus.full,     1'b0);
        chk("rst_rcving",   bus.rcving,   1'b0);
        chk("rst_r_error",  bus.r_error,  1'b0);
        chk("rst_pid",      bus.PID,      4'hF);
        chk("rst_pkt_done", bus.pkt_done, 1'b0);
        chk("rst_byte_cnt", bus.byte_cnt, 3'd0);
        rst = 1'b0;
        idle(4);

        // Eight zero bits where SYNC belongs
        done_cnt = 0;
        for (int i = 0; i < 8; i++) nrzi(1'b0);
        ones = 0;
        tx_byte(8'hE1);
        tx_byte(8'h55);
        tx_eop();
        idle(4);
        chk("badsync_err",   bus.r_error, 1'b1);
        chk("badsync_empty", bus.empty,   1'b1);
        chk("badsync_pid",   bus.PID,     4'hF);
        chk("badsync_done",  done_cnt,    0);
        chk("badsync_rcv",   bus.rcving,  1'b0);

        // OUT with one byte
        drain_on = 1'b1;
        got.delete(); done_cnt = 0;
        pl.delete(); pl.push_back(8'h55);
        tx_pkt(4'b0001);
        chk("out_pid",   bus.PID,      4'b0001);
        chk("out_n",     got.size(),   1);
        chk("out_b0",    got[0],       8'h55);
        chk("out_cnt",   bus.byte_cnt, 3'd1);
        chk("out_done",  done_cnt,     1);
        chk("out_err",   bus.r_error,  1'b0);
        chk("out_rcv",   bus.rcving,   1'b0);

        // DATA1 FF 3F exercising stuffed bits
        got.delete(); done_cnt = 0;
        pl.delete(); pl.push_back(8'hFF); pl.push_back(8'h3F);
        tx_pkt(4'b1011);
        chk("stuff_n",    got.size(),   2);
        chk("stuff_b0",   got[0],       8'hFF);
        chk("stuff_b1",   got[1],       8'h3F);
        chk("stuff_err",  bus.r_error,  1'b0);
        chk("stuff_done", done_cnt,     1);
        chk("stuff_pid",  bus.PID,      4'b1011);
        chk("stuff_cnt",  bus.byte_cnt, 3'd2);

        // Same packet, first stuffed bit sent as 1
        got.delete(); done_cnt = 0;
        corrupt = 1'b1;
        tx_pkt(4'b1011);
        chk("bstuff_err",  bus.r_error,  1'b1);
        chk("bstuff_done", done_cnt,     0);
        chk("bstuff_n",    got.size(),   0);
        chk("bstuff_cnt",  bus.byte_cnt, 3'd0);
        chk("bstuff_rcv",  bus.rcving,   1'b0);

        // Illegal PID 1111
        done_cnt = 0;
        pl.delete();
        tx_pkt(4'b1111);
        chk("pidF_err",  bus.r_error, 1'b1);
        chk("pidF_done", done_cnt,    0);
        chk("pidF_pid",  bus.PID,     4'b1011);

        // SE0 after four PID bits
        tx_sync();
        dbit(1'b1); dbit(1'b1); dbit(1'b0); dbit(1'b0);
        tx_eop();
        idle(4);
        chk("pidshort_err",  bus.r_error, 1'b1);
        chk("pidshort_done", done_cnt,    0);

        // ACK with no payload clears the error
        tx_pkt(4'b0010);
        chk("ack_err",  bus.r_error,  1'b0);
        chk("ack_pid",  bus.PID,      4'b0010);
        chk("ack_done", done_cnt,     1);
        chk("ack_cnt",  bus.byte_cnt, 3'd0);

        // Five bytes into a four-entry FIFO with no reads
        drain_on = 1'b0;
        got.delete(); done_cnt = 0;
        pl.delete();
        pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
        pl.push_back(8'h44); pl.push_back(8'h55);
        tx_pkt(4'b0011);
        chk("ovf_full", bus.full,     1'b1);
        chk("ovf_err",  bus.r_error,  1'b1);
        chk("ovf_done", done_cnt,     0);
        chk("ovf_cnt",  bus.byte_cnt, 3'd4);
        drain_on = 1'b1;
        repeat (10) @(negedge clk);
        chk("ovf_n",     got.size(), 4);
        chk("ovf_b0",    got[0],     8'h11);
        chk("ovf_b1",    got[1],     8'h22);
        chk("ovf_b3",    got[3],     8'h44);
        chk("ovf_empty", bus.empty,  1'b1);

        // Six bytes against a five-byte limit
        got.delete(); done_cnt = 0;
        pl.delete();
        for (int i = 1; i <= 6; i++) pl.push_back(8'(i));
        tx_pkt(4'b0011);
        chk("max_n",    got.size(),   5);
        chk("max_b0",   got[0],       8'h01);
        chk("max_b4",   got[4],       8'h05);
        chk("max_err",  bus.r_error,  1'b1);
        chk("max_done", done_cnt,     0);
        chk("max_cnt",  bus.byte_cnt, 3'd5);

        // Reset in the middle of DATA
        drain_on = 1'b0;
        got.delete(); done_cnt = 0;
        tx_sync();
        tx_byte(8'hC3);
        tx_byte(8'hAA);
        tx_byte(8'hBB);
        nrzi(1'b0);
        chk("mid_rcv",   bus.rcving,   1'b1);
        chk("mid_cnt",   bus.byte_cnt, 3'd2);
        chk("mid_empty", bus.empty,    1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_r_data", bus.r_data,   8'h00);
        chk("mrst_empty",  bus.empty,    1'b1);
        chk("mrst_full",   bus.full,     1'b0);
        chk("mrst_rcv",    bus.rcving,   1'b0);
        chk("mrst_err",    bus.r_error,  1'b0);
        chk("mrst_pid",    bus.PID,      4'hF);
        chk("mrst_done",   bus.pkt_done, 1'b0);
        chk("mrst_cnt",    bus.byte_cnt, 3'd0);
        rst = 1'b0;
        idle(6);
        drain_on = 1'b1;
        got.delete(); done_cnt = 0;
        pl.delete(); pl.push_back(8'h5A);
        tx_pkt(4'b1001);
        chk("post_pid",  bus.PID,     4'b1001);
        chk("post_n",    got.size(),  1);
        chk("post_b0",   got[0],      8'h5A);
        chk("post_done", done_cnt,    1);
        chk("post_err",  bus.r_error, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_rx_param.md
Name: usb_rx_param

Overview:
- Parametrised next-generation USB full-speed receive path. Decodes oversampled NRZI from d_plus/d_minus, detects SYNC, checks the PID, removes stuffed bits and pushes payload bytes into an internal show-ahead FIFO.
- Reports packet status (PID, byte count, done pulse, error) to the downstream packet/endpoint logic.
- Over the previous receiver it adds: configurable oversampling, configurable FIFO depth, bit-unstuffing with stuff-error detection, a maximum-length check, FIFO-overflow detection and a packet-done strobe.

Parameters:
- CLKS_PER_BIT, 8, clocks per USB bit time; must be ≥4.
- FIFO_DEPTH, 8, payload FIFO entries; power of 2, ≥2.
- MAX_BYTES, 64, maximum payload bytes per packet, excluding the PID.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset. Reset is synchronous and active-high.
- d_plus, input, 1, USB D+ (asynchronous).
- d_minus, input, 1, USB D- (asynchronous).
- r_enable, input, 1, pop the FIFO head.
- r_data, output, 8, FIFO head (show-ahead); 0 when empty.
- empty, output, 1, FIFO empty.
- full, output, 1, FIFO full.
- rcving, output, 1, a packet is in progress.
- r_error, output, 1, sticky packet error flag.
- PID, output, 4, last accepted PID.
- pkt_done, output, 1, one-cycle strobe when a valid packet ends.
- byte_cnt, output, $clog2(MAX_BYTES+1), payload bytes in the current or last packet.

Behaviour:
- Reset values:
  - r_data=0, empty=1, full=0, rcving=0, r_error=0, PID=4'hF, pkt_done=0, byte_cnt=0.
  - FIFO pointers cleared; FSM in IDLE.
  - Reset asserted mid-packet aborts the packet and drops all FIFO contents.
- Input conditioning:
  - Two-flop synchroniser on both lines.
  - Phase counter 0..CLKS_PER_BIT-1 restarts on any edge of synced d_plus.
  - Line is sampled when phase == CLKS_PER_BIT/2-1.
- Line decode:
  - J: D+=1, D-=0. K: D+=0, D-=1. SE0: both 0.
  - NRZI: bit=1 if the sample equals the previous sample, 0 if it differs.
- Bit-unstuffing (PID and DATA states only):
  - After six consecutive decoded 1s, the next bit is discarded.
  - If that discarded bit is 1, it is a stuff error.
- FSM:
  - IDLE: leave on the first K sample. Set rcving=1, clear r_error, byte_cnt=0, go to SYNC.
  - SYNC: shift 8 bits LSB-first. ==8'h80 goes to PID; otherwise error, go to ERR_WAIT.
  - PID: 8 bits. Valid when bits[7:4]==~bits[3:0] and bits[3:0] is in the legal set. If valid, register PID and go to DATA. If invalid, or SE0 arrives before 8 bits, error and go to ERR_WAIT.
  - DATA, byte boundary: each completed 8-bit byte is written to the FIFO one cycle after its last sample and byte_cnt increments.
  - DATA, write while full: byte dropped, error.
  - DATA, length limit: a byte when byte_cnt==MAX_BYTES is an error.
  - DATA, end of packet: SE0 goes to EOP if the bit counter is 0; otherwise error (partial byte).
  - EOP: one or more SE0 samples, then a J sample gives pkt_done=1 for one cycle, rcving=0, back to IDLE.
  - EOP, bad end: a K sample is an error.
  - ERR_WAIT: r_error=1; remain until SE0 followed by J (or 8 consecutive J bits), then rcving=0 and go to IDLE.
  - Error packets never assert pkt_done. Bytes already written stay in the FIFO.
- FIFO:
  - r_enable while empty is ignored.
  - Simultaneous push and pop while full: the pop occurs first and the push succeeds.
  - Simultaneous push and pop while empty: the push is accepted, empty stays 1 for that cycle, r_data appears next cycle.
  - Pointers wrap modulo FIFO_DEPTH; one extra MSB distinguishes full from empty.
- PID holds its value until the next valid PID is accepted. Back-to-back packets with no idle gap beyond EOP must be accepted.

Decomposition:
- Package usb_rx_pkg holds:
  - Line/state enums: J/K/SE0, FSM states.
  - SYNC_BYTE=8'h80.
  - Legal PID constants: OUT 0001, IN 1001, SOF 0101, SETUP 1101, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
  - pid_is_legal function.
- Sub-module usb_rx_fifo (params DEPTH, WIDTH=8) implements the show-ahead FIFO. Top level holds the synchroniser, timing recovery, decoder, unstuffer and FSM.

Test Plan:
- SYNC, PID 0001, byte 8'h55, EOP → PID=0001, FIFO holds 8'h55, byte_cnt=1, pkt_done pulses once, r_error=0.
- SYNC, PID 1011, bytes 8'hFF then 8'h3F (stuffed 0 inserted after six 1s) → FIFO reads FF then 3F, no error. Same packet with the stuffed bit sent as 1 → r_error=1, no pkt_done.
- 8 zero bits instead of SYNC, then PID and a byte → r_error=1, FIFO empty, PID stays 4'hF.
- SYNC, PID 4'b1111 → r_error=1. SYNC, PID with SE0 after 4 bits → r_error=1. A following good packet (PID 0010) clears r_error and sets PID=0010.
- FIFO_DEPTH=4, 5-byte packet with no reads → full=1 after 4 bytes, 5th dropped, r_error=1; reads return the first 4 bytes in order.
- Assert rst mid-DATA after 2 bytes → all outputs at reset values the next cycle; next full packet decodes correctly.
